arm_pipelined_cond_unit: RTL and testbench
==========================================

Name: arm_pipelined_cond_unit

Overview:
- Control-side pipeline of the ARM pipelined core, directly downstream of the decode-stage controller decoder.
- Registers the decoded control bits Decode→Execute→Memory→WriteBack.
- Evaluates the condition field in Execute against the architectural NZCV flag register and updates those flags.
- Squashes side effects of failed-condition instructions and drives the Execute/Memory/WriteBack control outputs consumed by the datapath and hazard unit.

Parameters:
ResetFlags, 4'b0000, NZCV value loaded on reset (bit3=N, bit2=Z, bit1=C, bit0=V)

Ports:
i_CLK  in  1  clock, rising edge
i_RESET  in  1  asynchronous reset, active-high
i_Cond  in  4  condition field of the instruction in Decode
i_PC_Src_Decode  in  1  instruction writes PC (branch or Rd=R15)
i_Reg_Write_Decode  in  1  register-file write
i_Mem_Write_Decode  in  1  data-memory write
i_Mem_To_Reg_Decode  in  1  writeback source is memory
i_Branch_Decode  in  1  B instruction
i_ALU_Src_Decode  in  1  ALU operand B is immediate
i_ALU_Control_Decode  in  2  ALU operation
i_Flag_Write_Decode  in  2  [1]=update N,Z; [0]=update C,V
i_ALU_Flags  in  4  NZCV produced by the ALU for the instruction in Execute
i_Flush_Execute  in  1  from hazard unit: load bubble into Execute
o_Branch_Taken_Execute  out  1  Branch_E & CondEx
o_PC_Src_Execute  out  1  PC_Src_E & CondEx (hazard unit)
o_PC_Src_Memory  out  1  registered
o_PC_Src_WriteBack  out  1  registered
o_ALU_Src_Execute  out  1  registered
o_ALU_Control_Execute  out  2  registered
o_Mem_To_Reg_Execute  out  1  registered, ungated (load-use detection)
o_Reg_Write_Memory  out  1  registered
o_Mem_Write_Memory  out  1  registered
o_Mem_To_Reg_WriteBack  out  1  registered
o_Reg_Write_WriteBack  out  1  registered
o_Flags  out  4  current NZCV register

Behaviour:
- Reset (async, i_RESET=1): every pipeline register is cleared to 0 and the flags are set to ResetFlags. All outputs read 0 except o_Flags. The clear takes effect immediately, including mid-instruction, and no partial update survives.
- Execute register, on rising edge:
  - If i_Flush_Execute=1: Cond_E, all control bits and Flag_Write_E are loaded with 0 (bubble). Flush has priority.
  - Otherwise: all Decode inputs are captured.
  - There is no stall input; the Execute stage never holds.
- CondEx, combinational from Cond_E and the flag register:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL =1; F =0 (treated as never-execute).
- Gating in Execute: PC_Src, Reg_Write, Mem_Write, Branch and Flag_Write are ANDed with CondEx. ALU_Src, ALU_Control and Mem_To_Reg are ungated. A bubble (all zero, Cond=0) has no effects.
- Flag register updates on rising edge:
  - NZ ← i_ALU_Flags[3:2] iff Flag_Write_E[1]&CondEx.
  - CV ← i_ALU_Flags[1:0] iff Flag_Write_E[0]&CondEx.
  - The two halves update independently.
- Flag latency: the instruction entering Execute one cycle after a flag-setting instruction sees the updated flags. There is no combinational bypass from i_ALU_Flags to CondEx.
- Memory register, on rising edge, captures the gated Execute values:
  - PC_Src_E&CondEx, Reg_Write_E&CondEx, Mem_Write_E&CondEx, Mem_To_Reg_E.
- WriteBack register captures PC_Src_M, Reg_Write_M and Mem_To_Reg_M. Mem_Write is not propagated past Memory.
- Latency: a Decode input appears on *_Execute outputs 1 cycle after capture, on *_Memory after 2, and on *_WriteBack after 3.
- Simultaneous events:
  - Flush and a flag update on the same edge: the flag update from the instruction leaving Execute still occurs; only the Execute register is bubbled.
  - Flush does not affect the Memory or WriteBack registers.
- Width rules: there is no arithmetic. i_Cond values 0..F are all defined, and no X-propagation is allowed from an unused encoding.

Test Plan:
- Reset with ResetFlags=4'b0000, then deassert → all outputs 0, o_Flags=0000. Assert i_RESET mid-stream with Reg_Write in flight → o_Reg_Write_Memory/WriteBack drop to 0 in the same cycle without a clock edge.
- CMP (Flag_Write=11, Cond=E, i_ALU_Flags=0100) followed by BEQ (Branch=1, PC_Src=1, Cond=0) → o_Flags=0100 after the CMP edge; o_Branch_Taken_Execute=1 for the BEQ; o_PC_Src_WriteBack=1 three cycles after BEQ capture.
- With Z=0, issue BEQ → o_Branch_Taken_Execute=0, o_PC_Src_Memory=0. With Z=0, issue a conditional store (Cond=0, Mem_Write=1) → o_Mem_Write_Memory=0.
- Partial flag write: flags=1111, Flag_Write=01, i_ALU_Flags=0000 → o_Flags=1100. Then Cond=F with Flag_Write=11 → flags unchanged.
- Load (Mem_To_Reg=1, Reg_Write=1) with i_Flush_Execute=1 on its capture edge → o_Mem_To_Reg_Execute=0, and Memory/WriteBack Reg_Write stay 0. An older instruction already in Memory reaches WriteBack unaffected.
- Sweep all 16 conditions against all 16 NZCV values → o_PC_Src_Execute matches the CondEx table for every pair (256 checks).

Source files
------------

// File: rtl/arm_pipelined_cond_unit_if.sv
// Control bundle between the decode-side controller/datapath and the conditional pipeline unit.
interface arm_pipelined_cond_unit_if;
   logic [3:0] i_Cond;
   logic       i_PC_Src_Decode;
   logic       i_Reg_Write_Decode;
   logic       i_Mem_Write_Decode;
   logic       i_Mem_To_Reg_Decode;
   logic       i_Branch_Decode;
   logic       i_ALU_Src_Decode;
   logic [1:0] i_ALU_Control_Decode;
   logic [1:0] i_Flag_Write_Decode;
   logic [3:0] i_ALU_Flags;
   logic       i_Flush_Execute;

   logic       o_Branch_Taken_Execute;
   logic       o_PC_Src_Execute;
   logic       o_PC_Src_Memory;
   logic       o_PC_Src_WriteBack;
   logic       o_ALU_Src_Execute;
   logic [1:0] o_ALU_Control_Execute;
   logic       o_Mem_To_Reg_Execute;
   logic       o_Reg_Write_Memory;
   logic       o_Mem_Write_Memory;
   logic       o_Mem_To_Reg_WriteBack;
   logic       o_Reg_Write_WriteBack;
   logic [3:0] o_Flags;

   // Driver side: decoder, hazard unit and ALU flag source.
   modport master (
      output i_Cond, i_PC_Src_Decode, i_Reg_Write_Decode, i_Mem_Write_Decode,
             i_Mem_To_Reg_Decode, i_Branch_Decode, i_ALU_Src_Decode, i_ALU_Control_Decode,
             i_Flag_Write_Decode, i_ALU_Flags, i_Flush_Execute,
      input  o_Branch_Taken_Execute, o_PC_Src_Execute, o_PC_Src_Memory, o_PC_Src_WriteBack,
             o_ALU_Src_Execute, o_ALU_Control_Execute, o_Mem_To_Reg_Execute, o_Reg_Write_Memory,
             o_Mem_Write_Memory, o_Mem_To_Reg_WriteBack, o_Reg_Write_WriteBack, o_Flags
   );

   // Conditional pipeline unit side.
   modport slave (
      input  i_Cond, i_PC_Src_Decode, i_Reg_Write_Decode, i_Mem_Write_Decode,
             i_Mem_To_Reg_Decode, i_Branch_Decode, i_ALU_Src_Decode, i_ALU_Control_Decode,
             i_Flag_Write_Decode, i_ALU_Flags, i_Flush_Execute,
      output o_Branch_Taken_Execute, o_PC_Src_Execute, o_PC_Src_Memory, o_PC_Src_WriteBack,
             o_ALU_Src_Execute, o_ALU_Control_Execute, o_Mem_To_Reg_Execute, o_Reg_Write_Memory,
             o_Mem_Write_Memory, o_Mem_To_Reg_WriteBack, o_Reg_Write_WriteBack, o_Flags
   );
endinterface

// File: rtl/arm_pipelined_cond_unit.sv
// Control pipeline Decode->Execute->Memory->WriteBack with condition evaluation in Execute,
// NZCV flag register and squashing of failed-condition side effects.
module arm_pipelined_cond_unit #(
   parameter logic [3:0] ResetFlags = 4'b0000
) (
   input logic                       i_CLK,
   input logic                       i_RESET,
   arm_pipelined_cond_unit_if.slave  bus
);

   // Execute stage state
   logic [3:0] cond_e;
   logic       pc_src_e, reg_write_e, mem_write_e, mem_to_reg_e, branch_e, alu_src_e;
   logic [1:0] alu_control_e, flag_write_e;

   // Memory / WriteBack stage state
   logic       pc_src_m, reg_write_m, mem_write_m, mem_to_reg_m;
   logic       pc_src_w, reg_write_w, mem_to_reg_w;

   // Architectural flags, bit3=N bit2=Z bit1=C bit0=V
   logic [3:0] flags_q, flags_d;
   logic       cond_ex;
   logic       flag_n, flag_z, flag_c, flag_v;

   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

   // Execute register: capture decoded controls, or load a bubble when flushed.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         cond_e        <= 4'h0;
         pc_src_e      <= 1'b0;
         reg_write_e   <= 1'b0;
         mem_write_e   <= 1'b0;
         mem_to_reg_e  <= 1'b0;
         branch_e      <= 1'b0;
         alu_src_e     <= 1'b0;
         alu_control_e <= 2'b00;
         flag_write_e  <= 2'b00;
      end else if (bus.i_Flush_Execute) begin
         cond_e        <= 4'h0;
         pc_src_e      <= 1'b0;
         reg_write_e   <= 1'b0;
         mem_write_e   <= 1'b0;
         mem_to_reg_e  <= 1'b0;
         branch_e      <= 1'b0;
         alu_src_e     <= 1'b0;
         alu_control_e <= 2'b00;
         flag_write_e  <= 2'b00;
      end else begin
         cond_e        <= bus.i_Cond;
         pc_src_e      <= bus.i_PC_Src_Decode;
         reg_write_e   <= bus.i_Reg_Write_Decode;
         mem_write_e   <= bus.i_Mem_Write_Decode;
         mem_to_reg_e  <= bus.i_Mem_To_Reg_Decode;
         branch_e      <= bus.i_Branch_Decode;
         alu_src_e     <= bus.i_ALU_Src_Decode;
         alu_control_e <= bus.i_ALU_Control_Decode;
         flag_write_e  <= bus.i_Flag_Write_Decode;
      end
   end

   // Condition check of the Execute instruction against the registered flags only.
   always_comb begin
      cond_ex = 1'b0;
      unique case (cond_e)
         4'h0: cond_ex = flag_z;
         4'h1: cond_ex = ~flag_z;
         4'h2: cond_ex = flag_c;
         4'h3: cond_ex = ~flag_c;
         4'h4: cond_ex = flag_n;
         4'h5: cond_ex = ~flag_n;
         4'h6: cond_ex = flag_v;
         4'h7: cond_ex = ~flag_v;
         4'h8: cond_ex = flag_c & ~flag_z;
         4'h9: cond_ex = ~flag_c | flag_z;
         4'hA: cond_ex = (flag_n == flag_v);
         4'hB: cond_ex = (flag_n != flag_v);
         4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
         4'hD: cond_ex = flag_z | (flag_n != flag_v);
         4'hE: cond_ex = 1'b1;
         4'hF: cond_ex = 1'b0;
      endcase
   end

   // Next flags: NZ and CV halves update independently when the instruction executes.
   always_comb begin
      flags_d = flags_q;
      if (flag_write_e[1] & cond_ex) flags_d[3:2] = bus.i_ALU_Flags[3:2];
      if (flag_write_e[0] & cond_ex) flags_d[1:0] = bus.i_ALU_Flags[1:0];
   end

   // Flag register.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) flags_q <= ResetFlags;
      else         flags_q <= flags_d;
   end

   // Memory and WriteBack registers; flush never touches these.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         pc_src_m     <= 1'b0;
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
         pc_src_w     <= 1'b0;
         reg_write_w  <= 1'b0;
         mem_to_reg_w <= 1'b0;
      end else begin
         pc_src_m     <= pc_src_e & cond_ex;
         reg_write_m  <= reg_write_e & cond_ex;
         mem_write_m  <= mem_write_e & cond_ex;
         mem_to_reg_m <= mem_to_reg_e;
         pc_src_w     <= pc_src_m;
         reg_write_w  <= reg_write_m;
         mem_to_reg_w <= mem_to_reg_m;
      end
   end

   // Output drive; Mem_To_Reg in Execute stays ungated for load-use detection.
   always_comb begin
      bus.o_Branch_Taken_Execute = branch_e & cond_ex;
      bus.o_PC_Src_Execute       = pc_src_e & cond_ex;
      bus.o_PC_Src_Memory        = pc_src_m;
      bus.o_PC_Src_WriteBack     = pc_src_w;
      bus.o_ALU_Src_Execute      = alu_src_e;
      bus.o_ALU_Control_Execute  = alu_control_e;
      bus.o_Mem_To_Reg_Execute   = mem_to_reg_e;
      bus.o_Reg_Write_Memory     = reg_write_m;
      bus.o_Mem_Write_Memory     = mem_write_m;
      bus.o_Mem_To_Reg_WriteBack = mem_to_reg_w;
      bus.o_Reg_Write_WriteBack  = reg_write_w;
      bus.o_Flags                = flags_q;
   end

endmodule

// File: tb/tb_arm_pipelined_cond_unit.sv
// Self-checking bench: directed sequences, condition table, full sweep and random vs model.
module tb_arm_pipelined_cond_unit;
   localparam logic [3:0] ResetFlags = 4'b0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arm_pipelined_cond_unit_if bus ();
   arm_pipelined_cond_unit #(.ResetFlags(ResetFlags)) dut (.i_CLK(clk), .i_RESET(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] cond;
      logic       pc_src, reg_write, mem_write, mem_to_reg, branch, alu_src;
      logic [1:0] alu_ctrl, flag_write;
   } dec_t;

   typedef struct {
      logic [3:0] nzcv;
      logic [3:0] cond;
      logic       exp;
   } vec_t;

   // Reference model state
   dec_t       m_ex;
   logic [3:0] m_flags;
   logic       m_pc_m, m_rw_m, m_mw_m, m_mtr_m, m_pc_w, m_rw_w, m_mtr_w;

   // Condition pass: odd codes invert the predicate of the even code below them.
   function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, p;
      {n, z, cy, v} = f;
      case (c >> 1)
         0: p = z;
         1: p = cy;
         2: p = n;
         3: p = v;
         4: p = cy && !z;
         5: p = (n == v);
         6: p = !z && (n == v);
         default: p = 1'b1;
      endcase
      return p ^ c[0];
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input dec_t d, input logic flush, input logic [3:0] alu);
      bus.i_Cond               = d.cond;
      bus.i_PC_Src_Decode      = d.pc_src;
      bus.i_Reg_Write_Decode   = d.reg_write;
      bus.i_Mem_Write_Decode   = d.mem_write;
      bus.i_Mem_To_Reg_Decode  = d.mem_to_reg;
      bus.i_Branch_Decode      = d.branch;
      bus.i_ALU_Src_Decode     = d.alu_src;
      bus.i_ALU_Control_Decode = d.alu_ctrl;
      bus.i_Flag_Write_Decode  = d.flag_write;
      bus.i_Flush_Execute      = flush;
      bus.i_ALU_Flags          = alu;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic dec_t mk(input logic [3:0] cond, input logic pc, input logic rw,
                               input logic mw, input logic mtr, input logic br,
                               input logic [1:0] fw);
      dec_t d;
      d = '0;
      d.cond = cond; d.pc_src = pc; d.reg_write = rw; d.mem_write = mw;
      d.mem_to_reg = mtr; d.branch = br; d.flag_write = fw;
      return d;
   endfunction

   task automatic model_reset();
      m_ex = '0; m_flags = ResetFlags;
      {m_pc_m, m_rw_m, m_mw_m, m_mtr_m, m_pc_w, m_rw_w, m_mtr_w} = '0;
   endtask

   // Advance the model by one clock edge given the inputs present at that edge.
   task automatic model_edge(input dec_t d, input logic flush, input logic [3:0] alu);
      logic p;
      p = ref_pass(m_ex.cond, m_flags);
      if (p && m_ex.flag_write[1]) m_flags[3:2] = alu[3:2];
      if (p && m_ex.flag_write[0]) m_flags[1:0] = alu[1:0];
      m_pc_w = m_pc_m; m_rw_w = m_rw_m; m_mtr_w = m_mtr_m;
      m_pc_m = m_ex.pc_src & p; m_rw_m = m_ex.reg_write & p;
      m_mw_m = m_ex.mem_write & p; m_mtr_m = m_ex.mem_to_reg;
      m_ex = flush ? '0 : d;
   endtask

   task automatic check_model();
      logic p;
      p = ref_pass(m_ex.cond, m_flags);
      chk("rnd_br_taken_e", {3'b0, bus.o_Branch_Taken_Execute}, {3'b0, m_ex.branch & p});
      chk("rnd_pc_src_e",   {3'b0, bus.o_PC_Src_Execute},       {3'b0, m_ex.pc_src & p});
      chk("rnd_alu_src_e",  {3'b0, bus.o_ALU_Src_Execute},      {3'b0, m_ex.alu_src});
      chk("rnd_alu_ctl_e",  {2'b0, bus.o_ALU_Control_Execute},  {2'b0, m_ex.alu_ctrl});
      chk("rnd_mtr_e",      {3'b0, bus.o_Mem_To_Reg_Execute},   {3'b0, m_ex.mem_to_reg});
      chk("rnd_pc_src_m",   {3'b0, bus.o_PC_Src_Memory},        {3'b0, m_pc_m});
      chk("rnd_rw_m",       {3'b0, bus.o_Reg_Write_Memory},     {3'b0, m_rw_m});
      chk("rnd_mw_m",       {3'b0, bus.o_Mem_Write_Memory},     {3'b0, m_mw_m});
      chk("rnd_pc_src_w",   {3'b0, bus.o_PC_Src_WriteBack},     {3'b0, m_pc_w});
      chk("rnd_rw_w",       {3'b0, bus.o_Reg_Write_WriteBack},  {3'b0, m_rw_w});
      chk("rnd_mtr_w",      {3'b0, bus.o_Mem_To_Reg_WriteBack}, {3'b0, m_mtr_w});
      chk("rnd_flags",      bus.o_Flags,                        m_flags);
   endtask

   task automatic check_all_zero(input string tag);
      logic [11:0] v;
      v = {bus.o_Branch_Taken_Execute, bus.o_PC_Src_Execute, bus.o_PC_Src_Memory,
           bus.o_PC_Src_WriteBack, bus.o_ALU_Src_Execute, bus.o_ALU_Control_Execute,
           bus.o_Mem_To_Reg_Execute, bus.o_Reg_Write_Memory, bus.o_Mem_Write_Memory,
           bus.o_Mem_To_Reg_WriteBack, bus.o_Reg_Write_WriteBack};
      chk({tag, "_ctrl_hi"}, {2'b0, v[11:10]}, 4'h0);
      chk({tag, "_ctrl_md"}, v[9:6], 4'h0);
      chk({tag, "_ctrl_lo"}, v[5:2], 4'h0);
      chk({tag, "_ctrl_ll"}, {2'b0, v[1:0]}, 4'h0);
      chk({tag, "_flags"}, bus.o_Flags, ResetFlags);
   endtask

   // Load flags via an AL flag-setting instruction, then execute a branch with cond c.
   task automatic run_cond(input logic [3:0] c, input logic [3:0] nzcv, output logic taken,
                           output logic pc_e);
      drive(mk(4'hE, 0, 0, 0, 0, 0, 2'b11), 1'b0, 4'h0);
      step();
      drive(mk(c, 1, 0, 0, 0, 1, 2'b00), 1'b0, nzcv);
      step();
      chk("cond_flags_loaded", bus.o_Flags, nzcv);
      taken = bus.o_Branch_Taken_Execute;
      pc_e  = bus.o_PC_Src_Execute;
   endtask

   initial begin
      vec_t       tbl[19];
      logic       taken, pc_e;
      dec_t       d;
      logic       fl;
      logic [3:0] alu;

      tbl = '{
         '{4'b0100, 4'h0, 1'b1}, '{4'b0000, 4'h0, 1'b0}, '{4'b0000, 4'h1, 1'b1},
         '{4'b0010, 4'h2, 1'b1}, '{4'b0000, 4'h3, 1'b1}, '{4'b1000, 4'h4, 1'b1},
         '{4'b1000, 4'h5, 1'b0}, '{4'b0001, 4'h6, 1'b1}, '{4'b0001, 4'h7, 1'b0},
         '{4'b0010, 4'h8, 1'b1}, '{4'b0110, 4'h8, 1'b0}, '{4'b0110, 4'h9, 1'b1},
         '{4'b1001, 4'hA, 1'b1}, '{4'b1000, 4'hB, 1'b1}, '{4'b1001, 4'hC, 1'b1},
         '{4'b0101, 4'hC, 1'b0}, '{4'b0101, 4'hD, 1'b1}, '{4'b0000, 4'hE, 1'b1},
         '{4'b1111, 4'hF, 1'b0}
      };

      // Reset
      drive('0, 1'b0, 4'h0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      check_all_zero("reset");

      // CMP sets Z, BEQ taken, PC_Src reaches WriteBack three edges after capture
      drive(mk(4'hE, 0, 0, 0, 0, 0, 2'b11), 1'b0, 4'h0);
      step();
      drive(mk(4'h0, 1, 0, 0, 0, 1, 2'b00), 1'b0, 4'b0100);
      step();
      chk("cmp_flags", bus.o_Flags, 4'b0100);
      chk("beq_taken", {3'b0, bus.o_Branch_Taken_Execute}, 4'h1);
      chk("beq_pc_e", {3'b0, bus.o_PC_Src_Execute}, 4'h1);
      drive('0, 1'b0, 4'h0);
      step();
      chk("beq_pc_m", {3'b0, bus.o_PC_Src_Memory}, 4'h1);
      step();
      chk("beq_pc_w", {3'b0, bus.o_PC_Src_WriteBack}, 4'h1);

      // Z=0: BEQ not taken, conditional store squashed, AL store passes
      drive(mk(4'hE, 0, 0, 0, 0, 0, 2'b11), 1'b0, 4'h0);
      step();
      drive(mk(4'h0, 1, 0, 0, 0, 1, 2'b00), 1'b0, 4'b0000);
      step();
      chk("bne_taken", {3'b0, bus.o_Branch_Taken_Execute}, 4'h0);
      drive(mk(4'h0, 0, 0, 1, 0, 0, 2'b00), 1'b0, 4'h0);
      step();
      chk("bne_pc_m", {3'b0, bus.o_PC_Src_Memory}, 4'h0);
      drive(mk(4'hE, 0, 0, 1, 0, 0, 2'b00), 1'b0, 4'h0);
      step();
      chk("streq_mw_m", {3'b0, bus.o_Mem_Write_Memory}, 4'h0);
      drive('0, 1'b0, 4'h0);
      step();
      chk("stral_mw_m", {3'b0, bus.o_Mem_Write_Memory}, 4'h1);

      // Partial flag writes and never-condition
      drive(mk(4'hE, 0, 0, 0, 0, 0, 2'b11), 1'b0, 4'h0);
      step();
      drive(mk(4'hE, 0, 0, 0, 0, 0, 2'b01), 1'b0, 4'b1111);
      step();
      chk("flags_all_set", bus.o_Flags, 4'b1111);
      drive(mk(4'hF, 0, 0, 0, 0, 0, 2'b11), 1'b0, 4'b0000);
      step();
      chk("flags_cv_only", bus.o_Flags, 4'b1100);
      drive('0, 1'b0, 4'b0000);
      step();
      chk("flags_cond_never", bus.o_Flags, 4'b1100);

      // Flushed load behind an older register write
      drive(mk(4'hE, 0, 1, 0, 0, 0, 2'b00), 1'b0, 4'h0);
      step();
      drive(mk(4'hE, 0, 1, 0, 1, 0, 2'b00), 1'b1, 4'h0);
      step();
      chk("flush_mtr_e", {3'b0, bus.o_Mem_To_Reg_Execute}, 4'h0);
      chk("older_rw_m", {3'b0, bus.o_Reg_Write_Memory}, 4'h1);
      drive('0, 1'b0, 4'h0);
      step();
      chk("older_rw_w", {3'b0, bus.o_Reg_Write_WriteBack}, 4'h1);
      chk("flush_rw_m", {3'b0, bus.o_Reg_Write_Memory}, 4'h0);
      step();
      chk("flush_rw_w", {3'b0, bus.o_Reg_Write_WriteBack}, 4'h0);

      // Flush on the same edge as a flag update: update still lands
      drive(mk(4'hE, 0, 0, 0, 0, 0, 2'b11), 1'b0, 4'h0);
      step();
      drive(mk(4'hE, 0, 1, 0, 0, 0, 2'b00), 1'b1, 4'b1010);
      step();
      chk("flush_flag_upd", bus.o_Flags, 4'b1010);
      chk("flush_bubble_rwm", {3'b0, bus.o_Reg_Write_Memory}, 4'h0);

      // Asynchronous reset mid-stream
      drive(mk(4'hE, 0, 1, 0, 0, 0, 2'b00), 1'b0, 4'h0);
      step();
      drive('0, 1'b0, 4'h0);
      step();
      step();
      chk("pre_rst_rw_w", {3'b0, bus.o_Reg_Write_WriteBack}, 4'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_rw_w", {3'b0, bus.o_Reg_Write_WriteBack}, 4'h0);
      chk("async_rst_flags", bus.o_Flags, ResetFlags);
      step();
      rst = 1'b0;

      // Hand-written condition table
      foreach (tbl[i]) begin
         run_cond(tbl[i].cond, tbl[i].nzcv, taken, pc_e);
         chk($sformatf("tbl%0d_taken", i), {3'b0, taken}, {3'b0, tbl[i].exp});
      end

      // Full 16x16 sweep
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            run_cond(4'(c), 4'(f), taken, pc_e);
            chk($sformatf("sweep_c%0h_f%0h", c, f), {3'b0, pc_e},
                {3'b0, ref_pass(4'(c), 4'(f))});
         end
      end

      // Random traffic against the model
      drive('0, 1'b0, 4'h0);
      step();
      rst = 1'b1;
      #2 rst = 1'b0;
      model_reset();
      for (int n = 0; n < 400; n++) begin
         d   = dec_t'($urandom);
         fl  = ($urandom_range(0, 7) == 0);
         alu = 4'($urandom);
         drive(d, fl, alu);
         step();
         model_edge(d, fl, alu);
         check_model();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
